// File: rtl/wt_store_tid_tracker.sv
// Write-through dcache store completion tracker: hands out AXI write TIDs,
// remembers each store's address and retires stores as B responses return.
module wt_store_tid_tracker #(
  parameter int unsigned TidWidth             = 3,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned AddrWidth            = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          req_valid_i,
  output logic                                          req_ready_o,
  input  logic [AddrWidth-1:0]                          req_addr_i,
  output logic [TidWidth-1:0]                           req_tid_o,
  input  logic                                          rsp_valid_i,
  input  logic [TidWidth-1:0]                           rsp_tid_i,
  input  logic                                          rsp_err_i,
  output logic                                          done_valid_o,
  output logic [AddrWidth-1:0]                          done_addr_o,
  output logic                                          done_err_o,
  output logic [$clog2(MaxOutstandingStores+1)-1:0]     outstanding_o,
  output logic                                          empty_o,
  output logic                                          spurious_o
);

  localparam int unsigned NumTids  = 2 ** TidWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstandingStores + 1);

  logic [NumTids-1:0]   busy_q, busy_d;
  logic [AddrWidth-1:0] addr_tbl_q [NumTids];
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 done_valid_q, done_valid_d;
  logic [AddrWidth-1:0] done_addr_q, done_addr_d;
  logic                 done_err_q, done_err_d;
  logic                 spurious_q, spurious_d;

  logic                 free_found;
  logic [TidWidth-1:0]  free_tid;
  logic                 below_limit;
  logic                 alloc;
  logic                 rsp_hit;

  // Lowest-index free TID; scanning downwards leaves the lowest one last.
  always_comb begin
    free_found = 1'b0;
    free_tid   = '0;
    for (int i = NumTids - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_tid   = TidWidth'(i);
      end
    end
  end

  // Ready depends only on registered state, so a same-cycle response never frees a slot early.
  assign below_limit = (cnt_q < CntWidth'(MaxOutstandingStores));
  assign req_ready_o = below_limit && free_found;
  assign req_tid_o   = free_tid;
  assign alloc       = req_valid_i && req_ready_o;
  assign rsp_hit     = rsp_valid_i && busy_q[rsp_tid_i];

  // Next-state for bitmap, counter, retire pulse and sticky spurious flag.
  always_comb begin
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    done_valid_d = 1'b0;
    done_addr_d  = done_addr_q;
    done_err_d   = done_err_q;
    spurious_d   = spurious_q;

    if (alloc) begin
      busy_d[free_tid] = 1'b1;
    end
    if (rsp_hit) begin
      busy_d[rsp_tid_i] = 1'b0;
      done_valid_d      = 1'b1;
      done_addr_d       = addr_tbl_q[rsp_tid_i];
      done_err_d        = rsp_err_i;
    end
    if (rsp_valid_i && !busy_q[rsp_tid_i]) begin
      spurious_d = 1'b1;
    end

    unique case ({alloc, rsp_hit})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= '0;
      cnt_q        <= '0;
      done_valid_q <= 1'b0;
      done_addr_q  <= '0;
      done_err_q   <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      done_valid_q <= done_valid_d;
      done_addr_q  <= done_addr_d;
      done_err_q   <= done_err_d;
      spurious_q   <= spurious_d;
    end
  end

  // Address table needs no reset: an entry is only read while its busy bit is set.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_tbl_q[free_tid] <= req_addr_i;
    end
  end

  assign done_valid_o  = done_valid_q;
  assign done_addr_o   = done_addr_q;
  assign done_err_o    = done_err_q;
  assign outstanding_o = cnt_q;
  assign empty_o       = (cnt_q == '0);
  assign spurious_o    = spurious_q;

endmodule
